// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (baud, length, parity, stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module uart_rx_cfg #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              rx,
  input  logic [DIV_W-1:0]  cfg_baud_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              out_frm_err,
  output logic              out_break,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BRKWAIT
  } state_t;

  localparam logic [3:0] DW4 = 4'(DATA_W);

  state_t state_q;
  state_t state_d;

  logic              s1;
  logic              rx_s;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        nb_q;
  logic              pen_q;
  logic              podd_q;
  logic              stop2_q;
  logic [3:0]        bit_idx_q;
  logic              stop_idx_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_acc_q;
  logic              par_err_q;
  logic              frm_q;
  logic              zero_q;

  logic [DIV_W-1:0]  div_eff;
  logic [3:0]        nb_eff;
  logic [DIV_W-1:0]  half;
  logic              last_cnt;
  logic              samp;
  logic              bit_v;
  logic              load;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] shift_in;

  assign div_eff = (cfg_baud_div < DIV_W'(4)) ? DIV_W'(4) : cfg_baud_div;
  assign nb_eff  = (cfg_data_bits < 4'd5 || cfg_data_bits > DW4)
                 ? DW4 : cfg_data_bits;
  assign half     = div_q >> 1;
  assign last_cnt = (cnt_q == div_q - DIV_W'(1));
  assign load     = (state_q == DONE) && (!out_valid || out_ready);

  // two-flop synchroniser on the raw pin
  always_ff @(posedge clk) begin
    if (!rstB) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic h1;
  logic h2;

  // history of rx_s for the 2-of-3 vote at mid-bit
  always_ff @(posedge clk) begin
    if (!rstB) begin
      h1 <= 1'b1;
      h2 <= 1'b1;
    end else begin
      h1 <= rx_s;
      h2 <= h1;
    end
  end

  assign samp  = (cnt_q == half + DIV_W'(1));
  assign bit_v = (h1 & h2) | (h1 & rx_s) | (h2 & rx_s);
`else
  assign samp  = (cnt_q == half);
  assign bit_v = rx_s;
`endif

  // right-align the assembled word for the configured length
  always_comb begin
    aligned  = sh_q;
    shift_in = sh_q;
    if (LSB_FIRST != 0) begin
      aligned  = sh_q >> (DW4 - nb_q);
      shift_in = {bit_v, sh_q[DATA_W-1:1]};
    end else begin
      shift_in = {sh_q[DATA_W-2:0], bit_v};
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstB) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (samp) state_d = bit_v ? IDLE : DATA;
      end
      DATA: begin
        if (samp && bit_idx_q == nb_q - 4'd1)
          state_d = pen_q ? PARITY : STOP;
      end
      PARITY: begin
        if (samp) state_d = STOP;
      end
      STOP: begin
        if (samp && (!stop2_q || stop_idx_q)) state_d = DONE;
      end
      DONE: begin
        state_d = rx_s ? IDLE : BRKWAIT;
      end
      BRKWAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bit-period counter, free-running modulo the latched divisor
  always_ff @(posedge clk) begin
    if (!rstB) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        START, DATA, PARITY, STOP:
          cnt_q <= last_cnt ? '0 : cnt_q + DIV_W'(1);
        default:
          cnt_q <= '0;
      endcase
    end
  end

  // frame datapath: config latch, shift register, error accumulation
  always_ff @(posedge clk) begin
    if (!rstB) begin
      div_q      <= '0;
      nb_q       <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      sh_q       <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            div_q      <= div_eff;
            nb_q       <= nb_eff;
            pen_q      <= cfg_par_en;
            podd_q     <= cfg_par_odd;
            stop2_q    <= cfg_stop2;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            sh_q       <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_q      <= 1'b0;
            zero_q     <= 1'b1;
          end
        end
        DATA: begin
          if (samp) begin
            sh_q      <= shift_in;
            par_acc_q <= par_acc_q ^ bit_v;
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_v) zero_q <= 1'b0;
          end
        end
        PARITY: begin
          if (samp) begin
            par_err_q <= (par_acc_q ^ bit_v) != podd_q;
            if (bit_v) zero_q <= 1'b0;
          end
        end
        STOP: begin
          if (samp) begin
            stop_idx_q <= 1'b1;
            if (!bit_v) frm_q  <= 1'b1;
            if (bit_v)  zero_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // output word register with valid/ready hold and overrun pulse
  always_ff @(posedge clk) begin
    if (!rstB) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_par_err <= 1'b0;
      out_frm_err <= 1'b0;
      out_break   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= aligned;
        out_par_err <= par_err_q;
        out_frm_err <= frm_q;
        out_break   <= zero_q;
      end else if (state_q == DONE) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames against a queue of expected words.
// Honours UART_RX_MAJORITY_EN for latency and the spike-rejection step.
module tb_uart_rx_cfg;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic              clk = 1'b0;
  logic              rstB;
  logic              rx;
  logic [DIV_W-1:0]  cfg_baud_div;
  logic [3:0]        cfg_data_bits;
  logic              cfg_par_en;
  logic              cfg_par_odd;
  logic              cfg_stop2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              out_frm_err;
  logic              out_break;
  logic              overrun;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frm;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int words = 0;
  int ovr_cnt = 0;
  int cur_div = 16;
  logic prev_valid = 1'b0;

  uart_rx_cfg #(
    .DATA_W(DATA_W),
    .DIV_W(DIV_W),
    .LSB_FIRST(1)
  ) dut (
    .clk(clk),
    .rstB(rstB),
    .rx(rx),
    .cfg_baud_div(cfg_baud_div),
    .cfg_data_bits(cfg_data_bits),
    .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_stop2(cfg_stop2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_par_err(out_par_err),
    .out_frm_err(out_frm_err),
    .out_break(out_break),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit spike);
    int h;
    h = cur_div / 2;
    rx = v;
    if (spike) begin
      tick(1 + h);
      rx = ~v;
      tick(1);
      rx = v;
      tick(cur_div - 2 - h);
    end else begin
      tick(cur_div);
    end
  endtask

  task automatic send(input logic [8:0] d, input int nb, input bit pen,
                      input bit pbit, input int nstop, input bit sval,
                      input int spike_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(sval);
    for (int i = 0; i < bits.size(); i++)
      drive_bit(bits[i], i == spike_bit);
    rx = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic p,
                      input logic f, input logic b);
    exp_t e;
    e.data = d;
    e.par  = p;
    e.frm  = f;
    e.brk  = b;
    sb.push_back(e);
  endtask

  initial begin
    int c0;
    int w0;
    rstB          = 1'b0;
    rx            = 1'b1;
    out_ready     = 1'b1;
    cfg_baud_div  = 16'd16;
    cfg_data_bits = 4'd8;
    cfg_par_en    = 1'b0;
    cfg_par_odd   = 1'b0;
    cfg_stop2     = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out_valid;
        if (overrun) ovr_cnt++;
        if (out_valid && out_ready) begin
          words++;
          chk("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("data", 32'(out_data), 32'(e.data));
            chk("par_err", 32'(out_par_err), 32'(e.par));
            chk("frm_err", 32'(out_frm_err), 32'(e.frm));
            chk("break", 32'(out_break), 32'(e.brk));
          end
        end
      end
    join_none

    tick(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_flags", {out_par_err, out_frm_err, out_break}, 0);
    chk("rst_overrun", 32'(overrun), 0);
    rstB = 1'b1;
    tick(5);

    // 8N1 0xA5 at div 16, with latency from start edge
    cur_div = 16;
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    send(9'h0A5, 8, 0, 0, 1, 1, -1);
    tick(4);
    chk("lat_a5", 32'(rise_cyc - c0), 32'(5 + 8 + 9 * 16 + MAJ));
    tick(2 * cur_div);

    // 7 bits even parity with parity bit 1, then odd parity
    cur_div       = 10;
    cfg_baud_div  = 16'd10;
    cfg_data_bits = 4'd7;
    cfg_par_en    = 1'b1;
    cfg_par_odd   = 1'b0;
    push(8'h41, 1'b1, 1'b0, 1'b0);
    send(9'h041, 7, 1, 1, 1, 1, -1);
    tick(2 * cur_div);
    cfg_par_odd = 1'b1;
    push(8'h41, 1'b0, 1'b0, 1'b0);
    send(9'h041, 7, 1, 1, 1, 1, -1);
    tick(2 * cur_div);

    // 5 bits, two stop bits, divisor 12
    cur_div       = 12;
    cfg_baud_div  = 16'd12;
    cfg_data_bits = 4'd5;
    cfg_par_en    = 1'b0;
    cfg_stop2     = 1'b1;
    push(8'h15, 1'b0, 1'b0, 1'b0);
    send(9'h015, 5, 0, 0, 2, 1, -1);
    tick(2 * cur_div);

    // short low glitch is a false start
    cur_div       = 16;
    cfg_baud_div  = 16'd16;
    cfg_data_bits = 4'd8;
    cfg_stop2     = 1'b0;
    w0 = words;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * cur_div);
    chk("glitch_words", 32'(words), 32'(w0));
    chk("glitch_valid", 32'(out_valid), 0);

    // overrun: second word dropped while first is held
    out_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0, 1'b0);
    send(9'h011, 8, 0, 0, 1, 1, -1);
    tick(2 * cur_div);
    send(9'h022, 8, 0, 0, 1, 1, -1);
    tick(3 * cur_div);
    chk("ovr_count", 32'(ovr_cnt), 1);
    chk("ovr_hold_valid", 32'(out_valid), 1);
    chk("ovr_hold_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick(2);
    chk("ovr_drain_valid", 32'(out_valid), 0);

    // stop bit sampled low: framing error, not a break
    push(8'h55, 1'b0, 1'b1, 1'b0);
    send(9'h055, 8, 0, 0, 1, 0, -1);
    tick(2 * cur_div);

    // break: rx low for 20 bit times
    w0 = words;
    push(8'h00, 1'b0, 1'b1, 1'b1);
    rx = 1'b0;
    tick(20 * cur_div);
    chk("brk_one_word", 32'(words), 32'(w0 + 1));
    rx = 1'b1;
    tick(3 * cur_div);
    chk("brk_no_more", 32'(words), 32'(w0 + 1));
    push(8'h33, 1'b0, 1'b0, 1'b0);
    send(9'h033, 8, 0, 0, 1, 1, -1);
    tick(2 * cur_div);

    // reset in the middle of 0x3C, then 0x5A
    w0 = words;
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    rstB = 1'b0;
    rx   = 1'b1;
    tick(2);
    chk("midrst_valid", 32'(out_valid), 0);
    rstB = 1'b1;
    tick(4);
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    send(9'h05A, 8, 0, 0, 1, 1, -1);
    tick(2 * cur_div);
    chk("midrst_words", 32'(words), 32'(w0 + 1));

`ifdef UART_RX_MAJORITY_EN
    // one-clock spike at mid-bit of data bit 0 is voted out
    push(8'h0F, 1'b0, 1'b0, 1'b0);
    send(9'h00F, 8, 0, 0, 1, 1, 1);
    tick(2 * cur_div);
`endif

    chk("ovr_total", 32'(ovr_cnt), 1);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
